// File: rtl/fifo_ctrl_mem_pkg.sv
// Shared constants, size helpers and the push/pop operation encoding for fifo_ctrl_mem.
package fifo_ctrl_mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_AF_TH      = 6;
  localparam int unsigned DEF_AE_TH      = 2;

  // Number of storage slots addressed by an aw-bit pointer.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  // Accepted operations this cycle, encoded as {push_accepted, pop_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_mem_if.sv
// Push/pop handshake and status bundle between a producer/consumer and the FIFO.
interface fifo_ctrl_mem_if
  import fifo_ctrl_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side.
  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ctrl_mem_mem_dp.sv
// mem_dp: DEPTH x DATA_WIDTH dual-port array, synchronous write, asynchronous read.
module fifo_ctrl_mem_mem_dp
  import fifo_ctrl_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_write_enable,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed slot on an accepted push.
  // NOTE: storage has no reset; the pointers and count define which words are
  // meaningful, and a resettable array would prevent RAM inference.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_write_enable) begin
      r_mem[i_write_addr] <= i_write_data;
    end
  end

  assign o_read_data = r_mem[i_read_addr];

endmodule

// File: rtl/fifo_ctrl_mem.sv
// Synchronous FIFO controller: owns read/write pointers, occupancy count, status
// and sticky error flags around the mem_dp storage array.
module fifo_ctrl_mem
  import fifo_ctrl_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_TH      = DEF_AF_TH,
  parameter int unsigned AE_TH      = DEF_AE_TH
) (
  input  logic           clk,
  input  logic           reset,
  fifo_ctrl_mem_if.slave io_fifo
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH);

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_AF   = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0]      CNT_AE   = CNT_W'(AE_TH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_acc;
  logic                  w_push_acc;
  fifo_op_e              w_op;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Status flags decode the registered count only, so they are glitch-free
  // relative to the same-cycle push/pop requests.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A pop frees a slot, so a full FIFO can still take a push in the same cycle.
  // An empty FIFO never forwards the incoming word straight to the output.
  assign w_pop_acc  = io_fifo.pop && !w_empty;
  assign w_push_acc = io_fifo.push && (!w_full || w_pop_acc);
  assign w_op       = fifo_op_e'({w_push_acc, w_pop_acc});

  fifo_ctrl_mem_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_dp (
    .clk            (clk),
    .i_write_enable (w_push_acc),
    .i_write_addr   (r_wr_ptr),
    .i_write_data   (io_fifo.data_in),
    .i_read_addr    (r_rd_ptr),
    .o_read_data    (w_rd_data)
  );

  // Pointer, occupancy, output register and sticky error flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_acc) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= w_rd_data;
      end
      r_valid_out <= w_pop_acc;

      case (w_op)
        OP_PUSH: r_count <= r_count + CNT_ONE;
        OP_POP:  r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (io_fifo.push && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      if (io_fifo.pop && !w_pop_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign io_fifo.data_out     = r_data_out;
  assign io_fifo.valid_out    = r_valid_out;
  assign io_fifo.count        = r_count;
  assign io_fifo.full         = w_full;
  assign io_fifo.empty        = w_empty;
  assign io_fifo.almost_full  = (r_count >= CNT_AF);
  assign io_fifo.almost_empty = (r_count <= CNT_AE);
  assign io_fifo.overflow     = r_overflow;
  assign io_fifo.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_mem.sv
// Directed testbench for fifo_ctrl_mem (DEPTH 8, AF_TH 6, AE_TH 2).
module tb_fifo_ctrl_mem;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl_mem_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

  fifo_ctrl_mem #(
    .DATA_WIDTH (10),
    .ADDR_WIDTH (3),
    .AF_TH      (6),
    .AE_TH      (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_fifo (bus)
  );

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic [9:0] d, input logic q);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle(1'b0, 10'h000, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", bus.almost_empty); end
    checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_full_af got %b%b want 00", bus.full, bus.almost_full); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", bus.overflow, bus.underflow); end
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 10'h000) begin errors++; $display("FAIL reset_out got %b/%h want 0/000", bus.valid_out, bus.data_out); end
  endtask

  task automatic test_basic();
    logic [9:0] words [3];
    words[0] = 10'b0010010001;
    words[1] = 10'b0001001010;
    words[2] = 10'b0010010011;
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, words[i], 1'b0);
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d want 3", bus.count); end
    checks++; if (bus.empty !== 1'b0 || bus.almost_empty !== 1'b0) begin errors++; $display("FAIL basic_flags got e=%b ae=%b want 0 0", bus.empty, bus.almost_empty); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 10'h000, 1'b1);
      checks++;
      if (bus.data_out !== words[i] || bus.valid_out !== 1'b1) begin
        errors++; $display("FAIL basic_pop%0d got %h/%b want %h/1", i, bus.data_out, bus.valid_out, words[i]);
      end
    end
    checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL basic_drained got e=%b c=%0d want 1 0", bus.empty, bus.count); end
    cycle(1'b0, 10'h000, 1'b0);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", bus.valid_out); end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 10'(i), 1'b0);
      checks++;
      if (bus.almost_full !== (i >= 6) || bus.full !== (i == 8) || bus.count !== 4'(i)) begin
        errors++; $display("FAIL fill%0d got af=%b f=%b c=%0d want af=%b f=%b c=%0d",
                            i, bus.almost_full, bus.full, bus.count, (i >= 6), (i == 8), i);
      end
    end
    cycle(1'b1, 10'h3FF, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL overflow got ov=%b c=%0d want 1 8", bus.overflow, bus.count); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 10'h000, 1'b1);
      checks++;
      if (bus.data_out !== 10'(i) || bus.valid_out !== 1'b1) begin
        errors++; $display("FAIL drain%0d got %h/%b want %h/1", i, bus.data_out, bus.valid_out, 10'(i));
      end
    end
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin errors++; $display("FAIL drain_end got e=%b ov=%b want 1 1", bus.empty, bus.overflow); end
  endtask

  // Runs straight after test_full_overflow: FIFO empty, data_out holds 0x008.
  task automatic test_underflow();
    cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL underflow got %b want 1", bus.underflow); end
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 10'h008) begin errors++; $display("FAIL underflow_out got %b/%h want 0/008", bus.valid_out, bus.data_out); end
    cycle(1'b1, 10'h155, 1'b1);
    checks++; if (bus.count !== 4'd1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL empty_pushpop got c=%0d v=%b want 1 0", bus.count, bus.valid_out); end
    checks++; if (bus.underflow !== 1'b1 || bus.data_out !== 10'h008) begin errors++; $display("FAIL empty_pushpop_hold got uf=%b d=%h want 1 008", bus.underflow, bus.data_out); end
    cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.data_out !== 10'h155 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL empty_pushpop_word got %h/%b want 155/1", bus.data_out, bus.valid_out); end
  endtask

  task automatic test_full_pushpop();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 10'h010 + 10'(i), 1'b0);
    cycle(1'b1, 10'h2AA, 1'b1);
    checks++; if (bus.data_out !== 10'h010 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL full_pushpop_out got %h/%b want 010/1", bus.data_out, bus.valid_out); end
    checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_state got c=%0d f=%b ov=%b want 8 1 0", bus.count, bus.full, bus.overflow); end
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 10'h000, 1'b1);
      checks++;
      if (bus.data_out !== 10'h010 + 10'(i)) begin errors++; $display("FAIL full_drain%0d got %h want %h", i, bus.data_out, 10'h010 + 10'(i)); end
    end
    cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.data_out !== 10'h2AA || bus.valid_out !== 1'b1) begin errors++; $display("FAIL wrap_word got %h/%b want 2AA/1", bus.data_out, bus.valid_out); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    apply_reset();
    cycle(1'b1, 10'h100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 10'h200 + 10'(i), 1'b1);
      exp = (i == 0) ? 10'h100 : 10'h200 + 10'(i - 1);
      checks++;
      if (bus.data_out !== exp || bus.valid_out !== 1'b1 || bus.count !== 4'd1) begin
        errors++; $display("FAIL b2b%0d got %h/%b c=%0d want %h/1 c=1", i, bus.data_out, bus.valid_out, bus.count, exp);
      end
    end
    cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.data_out !== 10'h213 || bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_last got %h e=%b want 213 1", bus.data_out, bus.empty); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 10'h040 + 10'(i), 1'b0);
    cycle(1'b1, 10'h3FF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.count !== 4'd5 || bus.overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got c=%0d ov=%b want 5 1", bus.count, bus.overflow); end
    reset = 1'b1;
    cycle(1'b1, 10'h111, 1'b1);
    reset = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_reset got c=%0d e=%b want 0 1", bus.count, bus.empty); end
    checks++; if (bus.overflow !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 10'h000) begin errors++; $display("FAIL mid_reset_out got ov=%b v=%b d=%h want 0 0 000", bus.overflow, bus.valid_out, bus.data_out); end
    cycle(1'b1, 10'h0AB, 1'b0);
    cycle(1'b0, 10'h000, 1'b1);
    checks++; if (bus.data_out !== 10'h0AB || bus.valid_out !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL mid_after got %h/%b c=%0d want 0AB/1 c=0", bus.data_out, bus.valid_out, bus.count); end
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 10'h000;
    test_reset();
    test_basic();
    test_full_overflow();
    test_underflow();
    test_full_pushpop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
